// File: rtl/inst_rom_loader_if.sv
// Fetch port and byte-serial loader handshake shared by the CPU/host side and the
// instruction memory.
interface inst_rom_loader_if;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;

    modport master (
        output ce_i,
        output addr_i,
        input  inst_o,
        output ld_start,
        output ld_valid,
        output ld_byte,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ce_i,
        input  addr_i,
        output inst_o,
        input  ld_start,
        input  ld_valid,
        input  ld_byte,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction memory with a zero-latency fetch port and a byte-serial boot loader
// that packs a streamed image big-endian into 32-bit words.
module inst_rom_loader #(
    parameter int unsigned ADDR_W         = 10,
    parameter bit          BOOT_FROM_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    inst_rom_loader_if.slave  bus,
    output logic              boot_done,
    output logic              ld_err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic              ld_err_q, ld_err_d;
    logic [31:0]       buf_q, buf_d;
    logic              last_q, last_d;
    logic              mem_we;
    logic [31:0]       shifted;
    logic [ADDR_W-1:0] rd_idx;

    logic [31:0] mem [Depth];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if (BOOT_FROM_INIT) begin
                state_q <= StRun;
            end else begin
                state_q <= StIdle;
            end
            byte_cnt_q <= '0;
            wr_ptr_q   <= '0;
            ld_err_q   <= 1'b0;
            buf_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            ld_err_q   <= ld_err_d;
            buf_q      <= buf_d;
            last_q     <= last_d;
        end
    end

    // Array has no reset so it can map onto block RAM and keep preloaded images.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= buf_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        ld_err_d   = ld_err_q;
        buf_d      = buf_q;
        last_d     = last_q;
        mem_we     = 1'b0;
        shifted    = {buf_q[23:0], bus.ld_byte};

        case (state_q)
            StIdle, StRun: begin
                if (bus.ld_start) begin
                    state_d    = StLoad;
                    byte_cnt_d = '0;
                    wr_ptr_d   = '0;
                    ld_err_d   = 1'b0;
                    buf_d      = '0;
                end
            end
            StLoad: begin
                if (bus.ld_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    buf_d      = shifted;
                    if (byte_cnt_q == 2'd3 || bus.ld_last) begin
                        state_d = StWrite;
                        last_d  = bus.ld_last;
                        // Left-justify a short final word, zero-filling the low bytes.
                        case (byte_cnt_q)
                            2'd0:    buf_d = {shifted[7:0], 24'h0};
                            2'd1:    buf_d = {shifted[15:0], 16'h0};
                            2'd2:    buf_d = {shifted[23:0], 8'h0};
                            default: buf_d = shifted;
                        endcase
                    end
                end
            end
            StWrite: begin
                if (!wr_ptr_q[ADDR_W]) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    ld_err_d = 1'b1;
                end
                byte_cnt_d = '0;
                state_d    = last_q ? StRun : StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rd_idx       = bus.addr_i[ADDR_W+1:2];
    assign bus.inst_o   = (bus.ce_i && state_q == StRun) ? mem[rd_idx] : 32'h0;
    assign bus.ld_ready = (state_q == StLoad);
    assign boot_done    = (state_q == StRun);
    assign ld_err       = ld_err_q;
    assign word_cnt     = wr_ptr_q;

    logic unused_addr;
    assign unused_addr = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: two instances (deep and 4-word) share one stimulus stream
// and are checked against an image-level memory model.
module tb_inst_rom_loader;

    localparam int unsigned AddrWA = 10;
    localparam int unsigned AddrWB = 2;
    localparam int DepthA = 1 << AddrWA;
    localparam int DepthB = 1 << AddrWB;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        ld_start, ld_valid, ld_last;
    logic [7:0]  ld_byte;

    logic              boot_done_a, boot_done_b, ld_err_a, ld_err_b;
    logic [AddrWA:0]   word_cnt_a;
    logic [AddrWB:0]   word_cnt_b;

    always #5 clk = ~clk;

    inst_rom_loader_if if_a ();
    inst_rom_loader_if if_b ();

    assign if_a.ce_i = ce;       assign if_b.ce_i = ce;
    assign if_a.addr_i = addr;   assign if_b.addr_i = addr;
    assign if_a.ld_start = ld_start; assign if_b.ld_start = ld_start;
    assign if_a.ld_valid = ld_valid; assign if_b.ld_valid = ld_valid;
    assign if_a.ld_byte = ld_byte;   assign if_b.ld_byte = ld_byte;
    assign if_a.ld_last = ld_last;   assign if_b.ld_last = ld_last;

    inst_rom_loader #(.ADDR_W(AddrWA), .BOOT_FROM_INIT(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a),
        .boot_done(boot_done_a), .ld_err(ld_err_a), .word_cnt(word_cnt_a)
    );

    inst_rom_loader #(.ADDR_W(AddrWB), .BOOT_FROM_INIT(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b),
        .boot_done(boot_done_b), .ld_err(ld_err_b), .word_cnt(word_cnt_b)
    );

    // Reference model: what each memory should hold, and which words are known.
    logic [31:0] model_a [DepthA];
    bit          known_a [DepthA];
    logic [31:0] model_b [DepthB];
    bit          known_b [DepthB];
    int          exp_cnt_a, exp_cnt_b;
    bit          exp_err_a, exp_err_b, exp_run;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_load(input byte_q_t img);
        int nw;
        logic [31:0] w;
        nw = (img.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w = {w[23:0], (4 * i + k < img.size()) ? img[4 * i + k] : 8'h00};
            end
            if (i < DepthA) begin model_a[i] = w; known_a[i] = 1'b1; end
            if (i < DepthB) begin model_b[i] = w; known_b[i] = 1'b1; end
        end
        exp_cnt_a = (nw < DepthA) ? nw : DepthA;
        exp_cnt_b = (nw < DepthB) ? nw : DepthB;
        exp_err_a = nw > DepthA;
        exp_err_b = nw > DepthB;
        exp_run   = 1'b1;
    endfunction

    task automatic verify_status(input string tag);
        check_eq({tag, "_boot_a"}, 32'(boot_done_a), 32'(exp_run));
        check_eq({tag, "_boot_b"}, 32'(boot_done_b), 32'(exp_run));
        check_eq({tag, "_err_a"}, 32'(ld_err_a), 32'(exp_err_a));
        check_eq({tag, "_err_b"}, 32'(ld_err_b), 32'(exp_err_b));
        check_eq({tag, "_cnt_a"}, 32'(word_cnt_a), 32'(exp_cnt_a));
        check_eq({tag, "_cnt_b"}, 32'(word_cnt_b), 32'(exp_cnt_b));
        check_eq({tag, "_rdy_a"}, 32'(if_a.ld_ready), 32'h0);
        check_eq({tag, "_rdy_b"}, 32'(if_b.ld_ready), 32'h0);
    endtask

    // Random aliased addresses into the known region; ce low must give NOP.
    task automatic verify_fetch(input string tag, input int n);
        int idx;
        logic [31:0] a;
        ce = 1'b1;
        for (int k = 0; k < n; k++) begin
            idx = $urandom_range(0, (exp_cnt_a > 0) ? exp_cnt_a - 1 : 0);
            a = $urandom;
            a[11:2] = idx[9:0];
            addr = a;
            #1;
            if (known_a[idx])
                check_eq({tag, "_fetch_a"}, if_a.inst_o, exp_run ? model_a[idx] : 32'h0);
            if (known_b[idx % DepthB])
                check_eq({tag, "_fetch_b"}, if_b.inst_o, exp_run ? model_b[idx % DepthB] : 32'h0);
        end
        ce = 1'b0;
        #1;
        check_eq({tag, "_nop_a"}, if_a.inst_o, 32'h0);
        check_eq({tag, "_nop_b"}, if_b.inst_o, 32'h0);
        ce = 1'b1;
    endtask

    task automatic check_ready_boot(input string tag, input logic rdy, input logic boot);
        check_eq({tag, "_rdy_a"}, 32'(if_a.ld_ready), 32'(rdy));
        check_eq({tag, "_rdy_b"}, 32'(if_b.ld_ready), 32'(rdy));
        check_eq({tag, "_boot_a"}, 32'(boot_done_a), 32'(boot));
        check_eq({tag, "_boot_b"}, 32'(boot_done_b), 32'(boot));
    endtask

    // Called at posedge+1 with the DUT in IDLE or RUN; returns at posedge+1 in RUN.
    task automatic load_image(input byte_q_t img, input int gap_pct, input bit poke_start);
        int  i, budget, n;
        bit  xfer;
        n = img.size();
        i = 0;
        budget = 0;
        ld_start = 1'b1;
        ld_valid = 1'($urandom_range(0, 1));
        ld_byte  = 8'($urandom);
        ld_last  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        while (i < n && budget < 40 * n + 50) begin
            budget++;
            xfer = 1'b0;
            ld_start = poke_start && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) >= gap_pct) begin
                ld_valid = 1'b1;
                ld_byte  = img[i];
                ld_last  = (i == n - 1);
                xfer     = 1'b1;
            end else begin
                ld_valid = 1'b0;
                ld_byte  = 8'($urandom);
                ld_last  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (xfer) begin
                i++;
                if (i == n || i % 4 == 0) begin
                    check_ready_boot("wr", 1'b0, 1'b0);
                    ld_start = 1'b0;
                    ld_valid = 1'($urandom_range(0, 1));
                    ld_byte  = 8'($urandom);
                    ld_last  = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    check_ready_boot("post_wr", i < n, i == n);
                end
            end
        end
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check_eq("load_done", 32'(i), 32'(n));
        model_load(img);
    endtask

    initial begin
        byte_q_t img8, img5, img;
        int len;

        for (int i = 0; i < DepthA; i++) known_a[i] = 1'b0;
        for (int i = 0; i < DepthB; i++) known_b[i] = 1'b0;
        exp_cnt_a = 0; exp_cnt_b = 0; exp_err_a = 0; exp_err_b = 0; exp_run = 0;

        rst = 1'b0; ce = 1'b1; addr = 32'h0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h0; ld_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        verify_status("rst");
        verify_fetch("rst", 3);

        // Bytes offered in IDLE must be ignored.
        rst = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_byte = 8'h5a; ld_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ld_valid = 1'b0; ld_last = 1'b0;
        verify_status("idle");
        verify_fetch("idle", 2);

        img8 = '{8'h24, 8'h02, 8'h00, 8'h05, 8'h34, 8'h03, 8'h00, 8'h07};
        load_image(img8, 0, 1'b0);
        verify_status("img8");
        addr = 32'h0; #1; check_eq("img8_addr0", if_a.inst_o, 32'h24020005);
        addr = 32'h4; #1; check_eq("img8_addr4", if_a.inst_o, 32'h34030007);
        addr = 32'h6; #1; check_eq("img8_addr6", if_a.inst_o, 32'h34030007);
        check_eq("img8_addr6_b", if_b.inst_o, 32'h34030007);
        verify_fetch("img8", 4);

        img5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hab};
        load_image(img5, 0, 1'b0);
        verify_status("img5");
        addr = 32'h4; #1; check_eq("img5_word1", if_a.inst_o, 32'hab000000);
        addr = 32'h0; #1; check_eq("img5_word0", if_a.inst_o, 32'h11223344);
        verify_fetch("img5", 4);

        load_image(img8, 50, 1'b0);
        verify_status("gap8");
        addr = 32'h0; #1; check_eq("gap8_addr0", if_a.inst_o, 32'h24020005);
        addr = 32'h4; #1; check_eq("gap8_addr4", if_a.inst_o, 32'h34030007);
        verify_fetch("gap8", 4);

        repeat (4) begin
            img = {};
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) img.push_back(8'($urandom));
            load_image(img, 30, 1'b1);
            verify_status("rnd");
            verify_fetch("rnd", 8);
        end

        // Five full words overflow the 4-word instance.
        img = {};
        for (int k = 0; k < 20; k++) img.push_back(8'($urandom));
        load_image(img, 20, 1'b0);
        verify_status("ovf");
        check_eq("ovf_err_b", 32'(ld_err_b), 32'h1);
        check_eq("ovf_cnt_b", 32'(word_cnt_b), 32'h4);
        verify_fetch("ovf", 8);

        // A new ld_start clears the sticky error; then reset mid-word.
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        check_eq("clr_err_b", 32'(ld_err_b), 32'h0);
        check_eq("clr_cnt_b", 32'(word_cnt_b), 32'h0);
        check_ready_boot("clr", 1'b1, 1'b0);
        ld_valid = 1'b1; ld_byte = 8'hde;
        @(posedge clk); #1;
        ld_byte = 8'had;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        rst = 1'b0;
        #1;
        exp_run = 0; exp_err_a = 0; exp_err_b = 0; exp_cnt_a = 0; exp_cnt_b = 0;
        verify_status("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        img = '{8'hca, 8'hfe, 8'hba, 8'hbe};
        load_image(img, 30, 1'b1);
        verify_status("after_rst");
        check_eq("after_rst_cnt", 32'(word_cnt_a), 32'h1);
        addr = 32'h0; #1; check_eq("after_rst_w0", if_a.inst_o, 32'hcafebabe);
        check_eq("after_rst_w0_b", if_b.inst_o, 32'hcafebabe);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
